reset_seq: RTL and testbench

RESET_SEQ -- requirements
Module: reset_seq

---
 rtl/reset_seq.sv | 153 +++++++++++++++
 tb/tb_reset_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/reset_seq.sv
// reset_seq: staggered multi-domain reset sequencer.
//
// All domains are held in reset for RESET_CYCLES, then released one at a time
// in ascending order, STAGGER_CYCLES apart. A level request (ext_rst_req) or a
// one-cycle software pulse (sys_rst_req) restarts the whole sequence.
//
// Optional feature macro: RESET_SEQ_CAUSE_EN
//   defined   -> rst_cause records the source of the last reset entry
//   undefined -> rst_cause is tied to 00 and no cause register is built
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_ASSERT  | all domains in reset, counting the RESET_CYCLES hold
// ST_RELEASE | domains being released one per STAGGER_CYCLES interval
// ST_RUN     | every domain released, waiting for the next reset request

module reset_seq #(
   parameter int NUM_DOMAINS    = 4,
   parameter int RESET_CYCLES   = 200,
   parameter int STAGGER_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ext_rst_req,
   input  logic                   sys_rst_req,
   output logic [NUM_DOMAINS-1:0] rst_n,
   output logic                   busy,
   output logic [1:0]             rst_cause
);

   localparam int MAX_CYC = (RESET_CYCLES > STAGGER_CYCLES) ? RESET_CYCLES : STAGGER_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int IDX_W   = $clog2(NUM_DOMAINS + 1);

   localparam logic [CNT_W-1:0] RST_TC   = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] STG_TC   = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic [IDX_W-1:0]       r_idx;
   logic [IDX_W-1:0]       w_idx_nxt;
   logic [NUM_DOMAINS-1:0] r_rst_n;
   logic [NUM_DOMAINS-1:0] w_rst_n_nxt;

   // State, counter, domain index and reset outputs; rst forces a clean restart.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_ASSERT;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_rst_n <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_rst_n <= w_rst_n_nxt;
      end
   end

   // Next-state logic: ext/sys requests override sequencing; the counter
   // never wraps because it is cleared on every terminal count.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_rst_n_nxt = r_rst_n;
      if (ext_rst_req || sys_rst_req) begin
         w_state_nxt = ST_ASSERT;
         w_cnt_nxt   = '0;
         w_idx_nxt   = '0;
         w_rst_n_nxt = '0;
      end else begin
         case (r_state)
            ST_ASSERT: begin
               if (r_cnt == RST_TC) begin
                  w_cnt_nxt      = '0;
                  w_rst_n_nxt[0] = 1'b1;
                  if (NUM_DOMAINS == 1) begin
                     w_state_nxt = ST_RUN;
                  end else begin
                     w_state_nxt = ST_RELEASE;
                     w_idx_nxt   = IDX_W'(1);
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            ST_RELEASE: begin
               if (r_cnt == STG_TC) begin
                  w_cnt_nxt = '0;
                  for (int d = 0; d < NUM_DOMAINS; d++) begin
                     if (r_idx == IDX_W'(d)) begin
                        w_rst_n_nxt[d] = 1'b1;
                     end
                  end
                  if (r_idx == LAST_IDX) begin
                     w_state_nxt = ST_RUN;
                  end else begin
                     w_idx_nxt = r_idx + 1'b1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               w_state_nxt = ST_RUN;
            end
            default: begin
               w_state_nxt = ST_ASSERT;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_rst_n_nxt = '0;
            end
         endcase
      end
   end

   assign rst_n = r_rst_n;
   assign busy  = ~(&r_rst_n);

`ifdef RESET_SEQ_CAUSE_EN
   localparam logic [1:0] CAUSE_POR = 2'b01;
   localparam logic [1:0] CAUSE_SW  = 2'b10;
   localparam logic [1:0] CAUSE_EXT = 2'b11;

   logic [1:0] r_cause;

   // Record the highest-priority source of each reset entry; hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cause <= CAUSE_POR;
      end else if (ext_rst_req) begin
         r_cause <= CAUSE_EXT;
      end else if (sys_rst_req) begin
         r_cause <= CAUSE_SW;
      end
   end

   assign rst_cause = r_cause;
`else
   assign rst_cause = 2'b00;
`endif

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: directed plus randomized checks of reset_seq (3 domains,
// 4-cycle hold, 2-cycle stagger). The reference model only tracks how many
// edges have passed since the last reset event; domain i must be high once
// that count reaches RESET_CYCLES + i*STAGGER_CYCLES.

module tb_reset_seq;

   localparam int ND = 3;
   localparam int RC = 4;
   localparam int ST = 2;

`ifdef RESET_SEQ_CAUSE_EN
   localparam logic [1:0] C_POR = 2'b01;
   localparam logic [1:0] C_SW  = 2'b10;
   localparam logic [1:0] C_EXT = 2'b11;
`else
   localparam logic [1:0] C_POR = 2'b00;
   localparam logic [1:0] C_SW  = 2'b00;
   localparam logic [1:0] C_EXT = 2'b00;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ext_rst_req = 1'b0;
   logic          sys_rst_req = 1'b0;
   logic [ND-1:0] rst_n;
   logic          busy;
   logic [1:0]    rst_cause;

   int            checks = 0;
   int            failures = 0;

   // reference model state
   int            since = 0;
   logic [1:0]    m_cause = 2'b00;

   logic [ND-1:0] seq_tbl [9];

   reset_seq #(
      .NUM_DOMAINS   (ND),
      .RESET_CYCLES  (RC),
      .STAGGER_CYCLES(ST)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ext_rst_req(ext_rst_req),
      .sys_rst_req(sys_rst_req),
      .rst_n      (rst_n),
      .busy       (busy),
      .rst_cause  (rst_cause)
   );

   always #5 clk = ~clk;

   function automatic logic [ND-1:0] model_rstn();
      logic [ND-1:0] m;
      for (int i = 0; i < ND; i++) begin
         m[i] = (since >= RC + i * ST);
      end
      return m;
   endfunction

   function automatic logic model_busy();
      return (model_rstn() != {ND{1'b1}});
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, advance the model on the same edge, then compare.
   task automatic step(input logic r, input logic e, input logic s);
      rst         = r;
      ext_rst_req = e;
      sys_rst_req = s;
      @(posedge clk);
      if (r) begin
         since   = 0;
         m_cause = C_POR;
      end else if (e) begin
         since   = 0;
         m_cause = C_EXT;
      end else if (s) begin
         since   = 0;
         m_cause = C_SW;
      end else if (since < 100000) begin
         since++;
      end
      #1;
      chk("model_rst_n", 32'(rst_n), 32'(model_rstn()));
      chk("model_busy", 32'(busy), 32'(model_busy()));
      chk("model_cause", 32'(rst_cause), 32'(m_cause));
   endtask

   initial begin
      int ext_left;
      logic r_v;
      logic e_v;
      logic s_v;

      seq_tbl = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b011, 3'b011, 3'b111};

      // power-on reset
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("por_rst_n", 32'(rst_n), 32'(3'b000));
      chk("por_busy", 32'(busy), 32'(1'b1));
      chk("por_cause", 32'(rst_cause), 32'(C_POR));

      // staggered release after rst
      for (int k = 1; k <= 8; k++) begin
         step(1'b0, 1'b0, 1'b0);
         chk($sformatf("por_seq_%0d", k), 32'(rst_n), 32'(seq_tbl[k]));
      end
      chk("por_busy_low", 32'(busy), 32'(1'b0));
      chk("por_cause_run", 32'(rst_cause), 32'(C_POR));

      // software reset from RUN
      step(1'b0, 1'b0, 1'b1);
      chk("sw_rst_n", 32'(rst_n), 32'(3'b000));
      chk("sw_busy", 32'(busy), 32'(1'b1));
      for (int k = 1; k <= 8; k++) begin
         step(1'b0, 1'b0, 1'b0);
         chk($sformatf("sw_seq_%0d", k), 32'(rst_n), 32'(seq_tbl[k]));
      end
      chk("sw_cause", 32'(rst_cause), 32'(C_SW));

      // external hold during RELEASE
      step(1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 4; k++) step(1'b0, 1'b0, 1'b0);
      chk("ext_pre_rst_n", 32'(rst_n), 32'(3'b001));
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b1, 1'b0);
         chk($sformatf("ext_hold_%0d", k), 32'(rst_n), 32'(3'b000));
      end
      for (int k = 1; k <= 8; k++) begin
         step(1'b0, 1'b0, 1'b0);
         chk($sformatf("ext_seq_%0d", k), 32'(rst_n), 32'(seq_tbl[k]));
      end
      chk("ext_cause", 32'(rst_cause), 32'(C_EXT));

      // coincident requests
      step(1'b0, 1'b1, 1'b1);
      chk("ext_sys_cause", 32'(rst_cause), 32'(C_EXT));
      step(1'b1, 1'b1, 1'b1);
      chk("all_cause", 32'(rst_cause), 32'(C_POR));
      chk("all_rst_n", 32'(rst_n), 32'(3'b000));

      // software pulse at hold count 3 restarts the hold
      for (int k = 1; k <= 3; k++) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      chk("restart_rst_n", 32'(rst_n), 32'(3'b000));
      for (int k = 1; k <= 4; k++) begin
         step(1'b0, 1'b0, 1'b0);
         chk($sformatf("restart_%0d", k), 32'(rst_n), 32'((k == 4) ? 3'b001 : 3'b000));
      end
      chk("restart_cause", 32'(rst_cause), 32'(C_SW));

      // randomized traffic against the model
      ext_left = 0;
      for (int n = 0; n < 500; n++) begin
         r_v = ($urandom_range(0, 79) == 0);
         if (ext_left == 0 && $urandom_range(0, 39) == 0) begin
            ext_left = $urandom_range(1, 12);
         end
         e_v = (ext_left > 0);
         if (ext_left > 0) ext_left--;
         s_v = ($urandom_range(0, 29) == 0);
         step(r_v, e_v, s_v);
      end
      for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0);
      chk("final_rst_n", 32'(rst_n), 32'(3'b111));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
